// File: rtl/branch_predict_flush_unit_pkg.sv
// Shared definitions for the branch predictor: counter encodings, entry layout
// and the PC slicing helpers used to index and tag the prediction table.
package branch_predict_flush_unit_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int BP_MAX_ADDR_W = 64;
  localparam int BP_MAX_TAG_W  = 32;

  // Widest entry layout; pipeline registers keep only the low bits they need.
  typedef struct packed {
    logic                     valid;
    logic [BP_MAX_TAG_W-1:0]  tag;
    logic [BP_MAX_ADDR_W-1:0] target;
    logic [1:0]               cnt;
  } bp_entry_t;

  function automatic logic [BP_MAX_ADDR_W-1:0] bp_idx(input logic [BP_MAX_ADDR_W-1:0] pc,
                                                      input int idx_w);
    logic [BP_MAX_ADDR_W-1:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [BP_MAX_ADDR_W-1:0] bp_tag(input logic [BP_MAX_ADDR_W-1:0] pc,
                                                      input int idx_w,
                                                      input int tag_w);
    logic [BP_MAX_ADDR_W-1:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return (pc >> (idx_w + 2)) & mask;
  endfunction

endpackage

// File: rtl/branch_predict_flush_unit_table.sv
// Direct-mapped prediction table: async IF read, async resolve lookup and a
// single synchronous write port, all cleared by synchronous reset.
module bp_table
  import branch_predict_flush_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [ADDR_W-1:0] o_rd_target,
  output logic [1:0]        o_rd_cnt,
  input  logic [IDX_W-1:0]  i_lk_idx,
  output logic              o_lk_valid,
  output logic [TAG_W-1:0]  o_lk_tag,
  output logic [ADDR_W-1:0] o_lk_target,
  output logic [1:0]        o_lk_cnt,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [ADDR_W-1:0] i_wr_target,
  input  logic [1:0]        i_wr_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic              r_valid  [DEPTH];
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [ADDR_W-1:0] r_target [DEPTH];
  logic [1:0]        r_cnt    [DEPTH];

  // Reads return pre-write contents, so IF sees old state on a same-index update.
  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];
  assign o_rd_cnt    = r_cnt[i_rd_idx];

  assign o_lk_valid  = r_valid[i_lk_idx];
  assign o_lk_tag    = r_tag[i_lk_idx];
  assign o_lk_target = r_target[i_lk_idx];
  assign o_lk_cnt    = r_cnt[i_lk_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (i_we) begin
      r_valid[i_wr_idx]  <= 1'b1;
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
      r_cnt[i_wr_idx]    <= i_wr_cnt;
    end
  end

endmodule

// File: rtl/branch_predict_flush_unit.sv
// IF-stage branch prediction, resolve-stage mispredict detection with PC
// redirect and pipeline flush, table training and performance counters.
module branch_predict_flush_unit
  import branch_predict_flush_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int IDX_W        = 6,
  parameter int TAG_W        = 8,
  parameter int FLUSH_STAGES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [ADDR_W-1:0]       i_if_pc,
  output logic                    o_pred_taken,
  output logic [ADDR_W-1:0]       o_pred_target,
  input  logic                    i_res_valid,
  input  logic [ADDR_W-1:0]       i_res_pc,
  input  logic                    i_res_is_branch,
  input  logic                    i_res_is_jump,
  input  logic                    i_res_taken,
  input  logic [ADDR_W-1:0]       i_res_target,
  input  logic                    i_res_pred_taken,
  input  logic [ADDR_W-1:0]       i_res_pred_target,
  output logic                    o_redirect,
  output logic [ADDR_W-1:0]       o_redirect_addr,
  output logic [FLUSH_STAGES-1:0] o_flush,
  output logic [CNT_W-1:0]        o_perf_branches,
  output logic [CNT_W-1:0]        o_perf_mispredicts
);

  logic [IDX_W-1:0]  w_if_idx, w_res_idx;
  logic [TAG_W-1:0]  w_if_tag, w_res_tag;
  logic              w_rd_valid, w_lk_valid;
  logic [TAG_W-1:0]  w_rd_tag, w_lk_tag;
  logic [ADDR_W-1:0] w_rd_target, w_lk_target;
  logic [1:0]        w_rd_cnt, w_lk_cnt;
  logic              w_if_hit, w_lk_hit;
  logic              w_pred_taken;
  logic              w_act, w_taken_eff, w_mispredict, w_update;
  logic              w_we;
  logic [1:0]        w_cnt_next;
  logic [ADDR_W-1:0] w_wr_target;
  logic [CNT_W-1:0]  r_perf_branches, r_perf_mispredicts;

  assign w_if_idx  = IDX_W'(bp_idx(BP_MAX_ADDR_W'(i_if_pc), IDX_W));
  assign w_if_tag  = TAG_W'(bp_tag(BP_MAX_ADDR_W'(i_if_pc), IDX_W, TAG_W));
  assign w_res_idx = IDX_W'(bp_idx(BP_MAX_ADDR_W'(i_res_pc), IDX_W));
  assign w_res_tag = TAG_W'(bp_tag(BP_MAX_ADDR_W'(i_res_pc), IDX_W, TAG_W));

  bp_table #(
    .ADDR_W(ADDR_W),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_table (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_idx   (w_if_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_target(w_rd_target),
    .o_rd_cnt   (w_rd_cnt),
    .i_lk_idx   (w_res_idx),
    .o_lk_valid (w_lk_valid),
    .o_lk_tag   (w_lk_tag),
    .o_lk_target(w_lk_target),
    .o_lk_cnt   (w_lk_cnt),
    .i_we       (w_we),
    .i_wr_idx   (w_res_idx),
    .i_wr_tag   (w_res_tag),
    .i_wr_target(w_wr_target),
    .i_wr_cnt   (w_cnt_next)
  );

  assign w_if_hit      = w_rd_valid && (w_rd_tag == w_if_tag);
  assign w_pred_taken  = !i_reset && w_if_hit && w_rd_cnt[1];
  assign o_pred_taken  = w_pred_taken;
  assign o_pred_target = w_pred_taken ? w_rd_target : i_if_pc + ADDR_W'(4);

  // A jump flagged as a branch too is still a jump: always taken.
  assign w_act       = i_res_valid && (i_res_is_branch || i_res_is_jump);
  assign w_taken_eff = i_res_is_jump || i_res_taken;
  assign w_update    = w_act && !i_reset;

  assign w_mispredict = w_update &&
                        ((w_taken_eff != i_res_pred_taken) ||
                         (w_taken_eff && (i_res_target != i_res_pred_target)));

  assign o_redirect      = w_mispredict;
  assign o_redirect_addr = !w_mispredict ? '0 :
                           w_taken_eff   ? i_res_target : i_res_pc + ADDR_W'(4);
  assign o_flush         = {FLUSH_STAGES{w_mispredict}};

  assign w_lk_hit    = w_lk_valid && (w_lk_tag == w_res_tag);
  assign w_we        = w_update && (w_taken_eff || w_lk_hit);
  assign w_wr_target = w_taken_eff ? i_res_target : w_lk_target;

  // Training: jumps pin strong-taken, taken misses allocate weak-taken.
  always_comb begin
    w_cnt_next = w_lk_cnt;
    if (i_res_is_jump) begin
      w_cnt_next = CNT_ST;
    end else if (w_taken_eff) begin
      if (!w_lk_hit)
        w_cnt_next = CNT_WT;
      else if (w_lk_cnt != CNT_ST)
        w_cnt_next = w_lk_cnt + 2'd1;
    end else if (w_lk_cnt != CNT_SNT) begin
      w_cnt_next = w_lk_cnt - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_act)
        r_perf_branches <= r_perf_branches + CNT_W'(1);
      if (w_mispredict)
        r_perf_mispredicts <= r_perf_mispredicts + CNT_W'(1);
    end
  end

  assign o_perf_branches    = r_perf_branches;
  assign o_perf_mispredicts = r_perf_mispredicts;

endmodule

// File: tb/tb_branch_predict_flush_unit.sv
// Randomized and directed check of branch_predict_flush_unit against a
// table-level reference model; a second instance covers a 5-stage flush.
module tb_branch_predict_flush_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ifPc;
  logic        resValid, resIsBranch, resIsJump, resTaken, resPredTaken;
  logic [31:0] resPc, resTarget, resPredTarget;

  logic        predTaken, redirect;
  logic [31:0] predTarget, redirectAddr, perfBranches, perfMispredicts;
  logic [2:0]  flush;

  logic        predTaken5, redirect5;
  logic [31:0] predTarget5, redirectAddr5, perfBranches5, perfMispredicts5;
  logic [4:0]  flush5;

  int testCount = 0;
  int failCount = 0;

  bit          mValid  [64];
  int          mTag    [64];
  logic [31:0] mTarget [64];
  int          mCnt    [64];
  logic [31:0] mBranches, mMispredicts;

  branch_predict_flush_unit dut (
    .i_clk(clk), .i_reset(reset), .i_if_pc(ifPc),
    .o_pred_taken(predTaken), .o_pred_target(predTarget),
    .i_res_valid(resValid), .i_res_pc(resPc), .i_res_is_branch(resIsBranch),
    .i_res_is_jump(resIsJump), .i_res_taken(resTaken), .i_res_target(resTarget),
    .i_res_pred_taken(resPredTaken), .i_res_pred_target(resPredTarget),
    .o_redirect(redirect), .o_redirect_addr(redirectAddr), .o_flush(flush),
    .o_perf_branches(perfBranches), .o_perf_mispredicts(perfMispredicts)
  );

  branch_predict_flush_unit #(.FLUSH_STAGES(5)) dut5 (
    .i_clk(clk), .i_reset(reset), .i_if_pc(ifPc),
    .o_pred_taken(predTaken5), .o_pred_target(predTarget5),
    .i_res_valid(resValid), .i_res_pc(resPc), .i_res_is_branch(resIsBranch),
    .i_res_is_jump(resIsJump), .i_res_taken(resTaken), .i_res_target(resTarget),
    .i_res_pred_taken(resPredTaken), .i_res_pred_target(resPredTarget),
    .o_redirect(redirect5), .o_redirect_addr(redirectAddr5), .o_flush(flush5),
    .o_perf_branches(perfBranches5), .o_perf_mispredicts(perfMispredicts5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mValid[i] = 1'b0; mTag[i] = 0; mTarget[i] = 32'h0; mCnt[i] = 1;
    end
    mBranches = 0;
    mMispredicts = 0;
  endtask

  task automatic modelPredict(input logic [31:0] pc, output bit taken,
                              output logic [31:0] target);
    int i, t;
    i = int'((pc / 4) % 64);
    t = int'((pc / 256) % 256);
    taken  = mValid[i] && (mTag[i] == t) && (mCnt[i] >= 2);
    target = taken ? mTarget[i] : pc + 32'd4;
  endtask

  // One cycle: drive, check mid-cycle against the model, clock, train the model.
  task automatic applyStimulus(input logic [31:0] pc, input bit rst, input bit vld,
                               input logic [31:0] rPc, input bit br, input bit jmp,
                               input bit tkn, input logic [31:0] tgt, input bit pTkn,
                               input logic [31:0] pTgt);
    bit act, takenEff, mis, expPt, hit;
    logic [31:0] expTgt, expAddr;
    int i, t;
    ifPc = pc; reset = rst; resValid = vld; resPc = rPc; resIsBranch = br;
    resIsJump = jmp; resTaken = tkn; resTarget = tgt; resPredTaken = pTkn;
    resPredTarget = pTgt;
    #4;
    act = vld && (br || jmp) && !rst;
    takenEff = jmp || tkn;
    mis = act && ((takenEff != pTkn) || (takenEff && tgt != pTgt));
    if (rst) begin
      expPt = 1'b0; expTgt = pc + 32'd4;
    end else begin
      modelPredict(pc, expPt, expTgt);
    end
    expAddr = !mis ? 32'h0 : (takenEff ? tgt : rPc + 32'd4);
    checkOutput("predTaken", 64'(predTaken), 64'(expPt));
    checkOutput("predTarget", 64'(predTarget), 64'(expTgt));
    checkOutput("redirect", 64'(redirect), 64'(mis));
    checkOutput("redirectAddr", 64'(redirectAddr), 64'(expAddr));
    checkOutput("flush", 64'(flush), mis ? 64'h7 : 64'h0);
    checkOutput("flush5", 64'(flush5), mis ? 64'h1f : 64'h0);
    checkOutput("perfBranches", 64'(perfBranches), 64'(mBranches));
    checkOutput("perfMispredicts", 64'(perfMispredicts), 64'(mMispredicts));
    @(posedge clk);
    #1;
    if (rst) begin
      modelReset();
    end else if (act) begin
      i = int'((rPc / 4) % 64);
      t = int'((rPc / 256) % 256);
      hit = mValid[i] && (mTag[i] == t);
      mBranches++;
      if (mis) mMispredicts++;
      if (jmp) begin
        mValid[i] = 1'b1; mTag[i] = t; mTarget[i] = tgt; mCnt[i] = 3;
      end else if (takenEff) begin
        if (hit) begin
          mCnt[i] = (mCnt[i] < 3) ? mCnt[i] + 1 : 3; mTarget[i] = tgt;
        end else begin
          mValid[i] = 1'b1; mTag[i] = t; mTarget[i] = tgt; mCnt[i] = 2;
        end
      end else if (hit) begin
        mCnt[i] = (mCnt[i] > 0) ? mCnt[i] - 1 : 0;
      end
    end
  endtask

  logic [31:0] pcPool [8];

  initial begin
    bit          pt, vld, br, jmp, tkn, rst;
    logic [31:0] ptg, rPc, tgt;
    reset = 1'b1; ifPc = 32'h40; resValid = 0; resPc = 0; resIsBranch = 0;
    resIsJump = 0; resTaken = 0; resTarget = 0; resPredTaken = 0; resPredTarget = 0;
    @(posedge clk); @(posedge clk); #1;
    modelReset();

    // Post-reset idle lookup
    applyStimulus(32'h40, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkOutput("rstPredTarget", 64'(predTarget), 64'h44);
    checkOutput("rstPerf", 64'(perfBranches), 64'h0);

    // Taken branch mispredicted as not-taken, then predicted taken
    applyStimulus(32'h40, 0, 1, 32'h40, 1, 0, 1, 32'h100, 0, 32'h44);
    checkOutput("trainPredTaken", 64'(predTaken), 64'h1);
    checkOutput("trainPredTarget", 64'(predTarget), 64'h100);
    checkOutput("trainMispredicts", 64'(perfMispredicts), 64'h1);

    // Two not-taken resolutions then saturation at strong-not-taken
    applyStimulus(32'h40, 0, 1, 32'h40, 1, 0, 0, 32'h100, 1, 32'h100);
    applyStimulus(32'h40, 0, 1, 32'h40, 1, 0, 0, 32'h100, 1, 32'h100);
    checkOutput("ntPredTaken", 64'(predTaken), 64'h0);
    applyStimulus(32'h40, 0, 1, 32'h40, 1, 0, 0, 32'h100, 0, 32'h44);
    applyStimulus(32'h40, 0, 1, 32'h40, 1, 0, 1, 32'h100, 0, 32'h44);
    checkOutput("satPredTaken", 64'(predTaken), 64'h0);

    // Correctly predicted jump, then branch+jump flagged together
    applyStimulus(32'h80, 0, 1, 32'h80, 0, 1, 0, 32'h200, 1, 32'h200);
    checkOutput("jumpPredTarget", 64'(predTarget), 64'h200);
    applyStimulus(32'h80, 0, 1, 32'h80, 1, 1, 0, 32'h208, 1, 32'h200);

    // Aliasing entry replacement
    applyStimulus(32'h40, 0, 1, 32'h40, 1, 0, 1, 32'h100, 0, 32'h44);
    applyStimulus(32'h140, 0, 1, 32'h140, 1, 0, 1, 32'h300, 0, 32'h144);
    checkOutput("aliasNewHit", 64'(predTarget), 64'h300);
    applyStimulus(32'h40, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Resolution coincident with reset is dropped
    applyStimulus(32'h140, 1, 1, 32'h80, 1, 0, 1, 32'h500, 0, 32'h84);
    applyStimulus(32'h140, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkOutput("rstDropPerf", 64'(perfBranches), 64'h0);

    pcPool[0] = 32'h40;  pcPool[1] = 32'h80;  pcPool[2] = 32'h140;
    pcPool[3] = 32'h1040; pcPool[4] = 32'hFFFFFFFC; pcPool[5] = 32'h200;
    for (int n = 0; n < 600; n++) begin
      pcPool[6] = $urandom & 32'hFFFFFFFC;
      pcPool[7] = $urandom;
      rPc = pcPool[$urandom_range(0, 7)];
      vld = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 3) != 0);
      jmp = ($urandom_range(0, 4) == 0);
      tkn = $urandom_range(0, 1);
      tgt = ($urandom_range(0, 1) != 0) ? pcPool[$urandom_range(0, 5)] : $urandom;
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) != 0) begin
        modelPredict(rPc, pt, ptg);
      end else begin
        pt = $urandom_range(0, 1);
        ptg = ($urandom_range(0, 1) != 0) ? tgt : $urandom;
      end
      applyStimulus(pcPool[$urandom_range(0, 7)], rst, vld, rPc, br, jmp, tkn, tgt, pt, ptg);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
